// File: rtl/sync_fifo_pkg.sv
// Shared types and constants for the sync_fifo read-side streaming master.
package sync_fifo_pkg;

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} rd_state_t;

  localparam int FIFO_RD_LAT = 1;
  localparam int OBUF_DEPTH  = 4;

endpackage

// File: rtl/sync_fifo_rd_stream_obuf.sv
// stream_obuf: 4-entry circular {last, data} buffer with push side and valid/ready pop side.
module stream_obuf
  import sync_fifo_pkg::*;
#(
  parameter int DAT_BIT = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_push,
  input  logic               i_pushLast,
  input  logic [DAT_BIT-1:0] i_pushData,
  input  logic               i_ready,
  output logic               o_valid,
  output logic [DAT_BIT-1:0] o_data,
  output logic               o_last,
  output logic [2:0]         o_occ
);

  logic [DAT_BIT:0] r_mem [OBUF_DEPTH];
  logic [1:0]       r_wrPtr;
  logic [1:0]       r_rdPtr;
  logic [2:0]       r_occ;
  logic             w_pop;
  logic             w_push;

  assign o_valid = (r_occ != 3'd0);
  assign o_occ   = r_occ;
  assign {o_last, o_data} = r_mem[r_rdPtr];

  // A push into a full buffer is only taken when the head leaves in the same cycle.
  assign w_pop  = o_valid & i_ready;
  assign w_push = i_push & ((r_occ != 3'(OBUF_DEPTH)) | w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < OBUF_DEPTH; i++) r_mem[i] <= '0;
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_occ   <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wrPtr] <= {i_pushLast, i_pushData};
        r_wrPtr        <= r_wrPtr + 2'd1;
      end
      if (w_pop) r_rdPtr <= r_rdPtr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 3'd1;
        2'b01:   r_occ <= r_occ - 3'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: rtl/sync_fifo_rd_stream.sv
// Read-side burst master for sync_fifo presenting a valid/ready stream with a burst-end marker.
// Define SYNC_FIFO_RD_STREAM_PERF_EN to add saturating burst and stall counters.
module sync_fifo_rd_stream
  import sync_fifo_pkg::*;
#(
  parameter int ADR_BIT   = 6,
  parameter int DAT_BIT   = 32,
  parameter int BURST_LEN = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               flush,
  output logic               fifo_rd_req,
  input  logic               fifo_rd_gnt,
  input  logic [DAT_BIT-1:0] fifo_rd_dat,
  input  logic               fifo_empty,
  input  logic [ADR_BIT:0]   fifo_count,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [DAT_BIT-1:0] m_data,
  output logic               m_last,
  output logic               busy
`ifdef SYNC_FIFO_RD_STREAM_PERF_EN
  ,
  output logic [15:0]        perf_burst_cnt,
  output logic [15:0]        perf_stall_cnt
`endif
);

  localparam int                RW           = $clog2(BURST_LEN) + 1;
  localparam logic [ADR_BIT:0]  LP_BURST_CNT = (ADR_BIT + 1)'(BURST_LEN);
  localparam logic [RW-1:0]     LP_BURST_REM = RW'(BURST_LEN);

  rd_state_t     r_state;
  rd_state_t     w_stateNext;
  logic [RW-1:0] r_remaining;
  logic [RW-1:0] w_remainingNext;
  logic          r_inflight;
  logic          r_inflightLast;
  logic [2:0]    w_occ;
  logic          w_headroom;
  logic          w_grant;
  logic          w_startFull;
  logic          w_startShort;
  logic          w_lastAccept;
  logic          w_burstStart;

  // Leave room in the buffer for every word already in flight plus the new one.
  assign w_headroom   = (w_occ + {2'b00, r_inflight}) <= 3'(OBUF_DEPTH - FIFO_RD_LAT);
  assign fifo_rd_req  = (r_state == BURST) & (r_remaining != '0) & ~fifo_empty & w_headroom;
  assign w_grant      = fifo_rd_req & fifo_rd_gnt;
  assign w_startFull  = en & (fifo_count >= LP_BURST_CNT);
  assign w_startShort = en & flush & ~fifo_empty & (fifo_count < LP_BURST_CNT);
  assign w_lastAccept = m_valid & m_ready & m_last;
  assign w_burstStart = (r_state == IDLE) & (w_stateNext == BURST);
  assign busy         = (r_state != IDLE);

  always_comb begin
    w_stateNext     = r_state;
    w_remainingNext = r_remaining;
    case (r_state)
      IDLE: begin
        if (w_startFull) begin
          w_stateNext     = BURST;
          w_remainingNext = LP_BURST_REM;
        end else if (w_startShort) begin
          w_stateNext     = BURST;
          w_remainingNext = RW'(fifo_count);
        end
      end
      BURST: begin
        if (w_grant) begin
          w_remainingNext = r_remaining - RW'(1);
          if (r_remaining == RW'(1)) w_stateNext = DRAIN;
        end
      end
      DRAIN: begin
        if (w_lastAccept) w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_remaining    <= '0;
      r_inflight     <= 1'b0;
      r_inflightLast <= 1'b0;
    end else begin
      r_state        <= w_stateNext;
      r_remaining    <= w_remainingNext;
      r_inflight     <= w_grant;
      r_inflightLast <= w_grant & (r_remaining == RW'(1));
    end
  end

  stream_obuf #(
    .DAT_BIT(DAT_BIT)
  ) u_obuf (
    .clk        (clk),
    .rst        (rst),
    .i_push     (r_inflight),
    .i_pushLast (r_inflightLast),
    .i_pushData (fifo_rd_dat),
    .i_ready    (m_ready),
    .o_valid    (m_valid),
    .o_data     (m_data),
    .o_last     (m_last),
    .o_occ      (w_occ)
  );

`ifdef SYNC_FIFO_RD_STREAM_PERF_EN
  logic [15:0] r_perfBurstCnt;
  logic [15:0] r_perfStallCnt;

  assign perf_burst_cnt = r_perfBurstCnt;
  assign perf_stall_cnt = r_perfStallCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perfBurstCnt <= '0;
      r_perfStallCnt <= '0;
    end else begin
      if (w_burstStart && (r_perfBurstCnt != 16'hFFFF)) r_perfBurstCnt <= r_perfBurstCnt + 16'd1;
      if (m_valid && !m_ready && (r_perfStallCnt != 16'hFFFF)) r_perfStallCnt <= r_perfStallCnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_rd_stream.sv
// Self-checking bench for sync_fifo_rd_stream with a behavioural sync_fifo and a beat scoreboard.
// Perf counter checks are built when SYNC_FIFO_RD_STREAM_PERF_EN is defined.
module tb_sync_fifo_rd_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        flush = 1'b0;
  logic        fifoRdReq;
  logic        fifoRdGnt = 1'b0;
  logic [31:0] fifoRdDat = '0;
  logic        fifoEmpty;
  logic [6:0]  fifoCount = '0;
  logic        mValid;
  logic        mReady = 1'b0;
  logic [31:0] mData;
  logic        mLast;
  logic        busy;
`ifdef SYNC_FIFO_RD_STREAM_PERF_EN
  logic [15:0] perfBurstCnt;
  logic [15:0] perfStallCnt;
`endif

  logic [31:0] fifoMem [64];
  logic [5:0]  wrPtr = '0;
  logic [5:0]  rdPtr = '0;
  logic        wrReq = 1'b0;
  logic [31:0] wrData = '0;
  logic        fifoClr = 1'b0;
  int          cyc = 0;
  int          grantCyc[$];
  int          beatCyc[$];
  logic [32:0] sbQ[$];
  int          checks = 0;
  int          errors = 0;
  bit          prevStall = 1'b0;
  logic [31:0] prevData = '0;
  logic        prevLast = 1'b0;

  always #5 clk = ~clk;

  assign fifoEmpty = (fifoCount == 7'd0);

  sync_fifo_rd_stream #(
    .ADR_BIT(6),
    .DAT_BIT(32),
    .BURST_LEN(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .flush       (flush),
    .fifo_rd_req (fifoRdReq),
    .fifo_rd_gnt (fifoRdGnt),
    .fifo_rd_dat (fifoRdDat),
    .fifo_empty  (fifoEmpty),
    .fifo_count  (fifoCount),
    .m_valid     (mValid),
    .m_ready     (mReady),
    .m_data      (mData),
    .m_last      (mLast),
    .busy        (busy)
`ifdef SYNC_FIFO_RD_STREAM_PERF_EN
    ,
    .perf_burst_cnt (perfBurstCnt),
    .perf_stall_cnt (perfStallCnt)
`endif
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Behavioural sync_fifo: one-cycle read latency, state only moves on the clock edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifoClr) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
    end else begin
      if (fifoRdReq && fifoRdGnt) begin
        fifoRdDat <= fifoMem[rdPtr];
        rdPtr     <= rdPtr + 6'd1;
        grantCyc.push_back(cyc);
      end
      if (wrReq) begin
        fifoMem[wrPtr] <= wrData;
        wrPtr          <= wrPtr + 6'd1;
      end
      fifoCount <= fifoCount + 7'(wrReq) - 7'(fifoRdReq && fifoRdGnt);
    end
  end

  // Output monitor: handshakes seen here complete on the following rising edge.
  always @(negedge clk) begin
    logic [32:0] exp;
    if (rst) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("hold data", mData, prevData);
        checkOutput("hold last", mLast, prevLast);
      end
      if (mValid && mReady) begin
        beatCyc.push_back(cyc);
        if (sbQ.size() == 0) begin
          checkOutput("unexpected beat sb depth", 64'(sbQ.size()), 64'd1);
        end else begin
          exp = sbQ.pop_front();
          checkOutput("beat data", mData, exp[31:0]);
          checkOutput("beat last", mLast, exp[32]);
        end
      end
      prevStall = mValid && !mReady;
      prevData  = mData;
      prevLast  = mLast;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int base, input int n, input bit expectOut);
    for (int i = 0; i < n; i++) begin
      wrReq  = 1'b1;
      wrData = 32'(base + i);
      if (expectOut) sbQ.push_back({(i == n - 1), 32'(base + i)});
      tick();
    end
    wrReq = 1'b0;
  endtask

  task automatic waitIdle(input string tag, input bit toggleGnt);
    bit done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      if (toggleGnt) fifoRdGnt = ~fifoRdGnt;
      tick();
      if (!busy && !mValid && sbQ.size() == 0) done = 1'b1;
    end
    checkOutput(tag, done, 1);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int g0;
    int b0;
    bit got;

    tick();
    tick();
    checkOutput("reset m_valid", mValid, 0);
    checkOutput("reset m_data", mData, 0);
    checkOutput("reset m_last", mLast, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset rd_req", fifoRdReq, 0);
    rst = 1'b0;
    tick();

    $display("[TB] full-rate burst");
    applyStimulus(0, 8, 1);
    g0 = grantCyc.size();
    b0 = beatCyc.size();
    fifoRdGnt = 1'b1;
    mReady    = 1'b1;
    en        = 1'b1;
    waitIdle("t1 completes", 0);
    en = 1'b0;
    checkOutput("t1 grants", 64'(grantCyc.size() - g0), 8);
    if (grantCyc.size() >= g0 + 8 && beatCyc.size() >= b0 + 8) begin
      checkOutput("t1 grant span", 64'(grantCyc[g0 + 7] - grantCyc[g0]), 7);
      checkOutput("t1 first beat latency", 64'(beatCyc[b0] - grantCyc[g0]), 2);
      checkOutput("t1 beat span", 64'(beatCyc[b0 + 7] - beatCyc[b0]), 7);
    end
    checkOutput("t1 fifo empty", fifoEmpty, 1);

    $display("[TB] backpressure");
    applyStimulus(20, 8, 1);
    g0 = grantCyc.size();
    mReady = 1'b0;
    en     = 1'b1;
    tick();
    tick();
    en = 1'b0;
    for (int k = 0; k < 14; k++) tick();
    checkOutput("t2 grants while stalled", 64'(grantCyc.size() - g0), 4);
    checkOutput("t2 rd_req low", fifoRdReq, 0);
    checkOutput("t2 fifo count", fifoCount, 4);
    checkOutput("t2 m_valid", mValid, 1);
    checkOutput("t2 head data", mData, 20);
    mReady = 1'b1;
    waitIdle("t2 completes", 0);
    checkOutput("t2 total grants", 64'(grantCyc.size() - g0), 8);

    $display("[TB] flush short burst");
    applyStimulus(10, 3, 1);
    g0 = grantCyc.size();
    en    = 1'b1;
    flush = 1'b1;
    waitIdle("t3 flush completes", 0);
    en    = 1'b0;
    flush = 1'b0;
    checkOutput("t3 flush grants", 64'(grantCyc.size() - g0), 3);
    applyStimulus(10, 3, 0);
    g0 = grantCyc.size();
    b0 = beatCyc.size();
    en = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    checkOutput("t3 no-flush grants", 64'(grantCyc.size() - g0), 0);
    checkOutput("t3 no-flush beats", 64'(beatCyc.size() - b0), 0);
    checkOutput("t3 no-flush m_valid", mValid, 0);
    checkOutput("t3 no-flush busy", busy, 0);
    for (int i = 0; i < 3; i++) sbQ.push_back({(i == 2), 32'(10 + i)});
    flush = 1'b1;
    waitIdle("t3 leftover drained", 0);
    en    = 1'b0;
    flush = 1'b0;

    $display("[TB] grant gaps");
    applyStimulus(40, 8, 1);
    g0 = grantCyc.size();
    fifoRdGnt = 1'b0;
    en        = 1'b1;
    waitIdle("t4 completes", 1);
    en        = 1'b0;
    fifoRdGnt = 1'b1;
    checkOutput("t4 grants", 64'(grantCyc.size() - g0), 8);
    checkOutput("t4 fifo empty", fifoEmpty, 1);

    $display("[TB] reset mid-burst");
    applyStimulus(60, 8, 1);
    b0 = beatCyc.size();
    en = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      tick();
      if (beatCyc.size() - b0 >= 3) got = 1'b1;
    end
    checkOutput("t5 three beats", got, 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t5 async m_valid", mValid, 0);
    checkOutput("t5 async rd_req", fifoRdReq, 0);
    checkOutput("t5 async busy", busy, 0);
    checkOutput("t5 async m_data", mData, 0);
    sbQ.delete();
    en      = 1'b0;
    fifoClr = 1'b1;
    tick();
    tick();
    fifoClr = 1'b0;
    rst     = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    checkOutput("t5 idle busy", busy, 0);
    checkOutput("t5 idle rd_req", fifoRdReq, 0);
    checkOutput("t5 idle m_valid", mValid, 0);

`ifdef SYNC_FIFO_RD_STREAM_PERF_EN
    $display("[TB] perf counters");
    applyStimulus(70, 8, 1);
    en = 1'b1;
    waitIdle("t6 burst a", 0);
    en = 1'b0;
    applyStimulus(80, 8, 1);
    en = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      tick();
      if (mValid) got = 1'b1;
    end
    checkOutput("t6 valid seen", got, 1);
    mReady = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    mReady = 1'b1;
    waitIdle("t6 burst b", 0);
    en = 1'b0;
    checkOutput("t6 perf bursts", perfBurstCnt, 2);
    checkOutput("t6 perf stalls", perfStallCnt, 5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
